// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with majority-vote bit sampling, parity/framing/break
// detection and a synchronous receive FIFO (no fall-through).
module uart_rx_fifo #(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned BIT_RATE     = 9600,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          uart_rxd,
  input  logic                          uart_rx_en,
  output logic [PAYLOAD_BITS-1:0]       m_data,
  output logic [1:0]                    m_status,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  output logic                          break_det
);

  localparam int unsigned DIV_RAW = CLK_HZ / (BIT_RATE * OVERSAMPLE);
  localparam int unsigned DIV     = (DIV_RAW == 0) ? 1 : DIV_RAW;
  localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TICK_W  = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W   = $clog2(PAYLOAD_BITS);
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = PAYLOAD_BITS + 2;

  localparam logic [TICK_W-1:0] TICK_LO   = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2);
  localparam logic [TICK_W-1:0] TICK_HI   = TICK_W'(OVERSAMPLE / 2 + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StWaitHigh} state_e;

  state_e state_q, state_d;

  logic [1:0]              sync_q;
  logic                    line;
  logic [DIV_W-1:0]        div_q;
  logic [TICK_W-1:0]       tick_q;
  logic [BIT_W-1:0]        bit_q;
  logic                    stop_q;
  logic                    s0_q, s1_q;
  logic [PAYLOAD_BITS-1:0] shift_q;
  logic                    par_q;
  logic                    fe_q;

  logic tick, tick_last, maj_pt, maj, last_bit, last_stop, frame_err_now, parity_err;
  logic stop_exit, push, brk_evt;

  // Synchroniser idles high so a disabled or resetting receiver never sees a start edge.
  always_ff @(posedge clk) begin
    if (!resetn || !uart_rx_en) sync_q <= 2'b11;
    else                        sync_q <= {sync_q[0], uart_rxd};
  end
  assign line = sync_q[1];

  assign tick      = (div_q == DIV_W'(DIV - 1));
  assign tick_last = tick && (tick_q == TICK_LAST);
  assign maj_pt    = tick && (tick_q == TICK_HI);
  assign maj       = (s0_q & s1_q) | (s0_q & line) | (s1_q & line);
  assign last_bit  = (bit_q == BIT_W'(PAYLOAD_BITS - 1));
  assign last_stop = (stop_q == 1'(STOP_BITS - 1));
  assign frame_err_now = fe_q | ~maj;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_q   <= '0;
      tick_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
      shift_q <= '0;
      par_q   <= 1'b0;
      fe_q    <= 1'b0;
    end else if (state_q == StIdle || !uart_rx_en) begin
      div_q  <= '0;
      tick_q <= '0;
      bit_q  <= '0;
      stop_q <= 1'b0;
      fe_q   <= 1'b0;
    end else begin
      div_q <= tick ? '0 : div_q + DIV_W'(1);
      if (tick) begin
        tick_q <= (tick_q == TICK_LAST) ? '0 : tick_q + TICK_W'(1);
        if (tick_q == TICK_LO)  s0_q <= line;
        if (tick_q == TICK_MID) s1_q <= line;
      end
      if (maj_pt) begin
        if (state_q == StData)   shift_q <= {maj, shift_q[PAYLOAD_BITS-1:1]};
        if (state_q == StParity) par_q   <= maj;
        if (state_q == StStop && !maj) fe_q <= 1'b1;
      end
      if (tick_last) begin
        if (state_q == StData) bit_q  <= last_bit ? '0 : bit_q + BIT_W'(1);
        if (state_q == StStop) stop_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (!line) state_d = StStart;
      StStart: begin
        if (maj_pt && maj)  state_d = StIdle;
        else if (tick_last) state_d = StData;
      end
      StData:     if (tick_last && last_bit) state_d = (PARITY != 0) ? StParity : StStop;
      StParity:   if (tick_last) state_d = StStop;
      StStop:     if (maj_pt && last_stop) state_d = frame_err_now ? StWaitHigh : StIdle;
      StWaitHigh: if (line) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
    if (!uart_rx_en) state_d = StIdle;
  end

  always_comb begin
    parity_err = 1'b0;
    if (PARITY == 1)      parity_err = ~(^shift_q ^ par_q);
    else if (PARITY == 2) parity_err = ^shift_q ^ par_q;
    stop_exit = (state_q == StStop) && maj_pt && last_stop && uart_rx_en;
    brk_evt   = stop_exit && (shift_q == '0) && frame_err_now;
    push      = stop_exit && !brk_evt;
  end

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_q, rd_q;
  logic [CNT_W-1:0]   count_q;
  logic               full, pop, wr_en, overrun_q, break_q;
  logic [ENTRY_W-1:0] head;

  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop   = m_valid && m_ready;
  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_q] <= {frame_err_now, parity_err, shift_q};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      break_q   <= 1'b0;
    end else begin
      if (wr_en) wr_q <= wr_q + PTR_W'(1);
      if (pop)   rd_q <= rd_q + PTR_W'(1);
      unique case ({wr_en, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      overrun_q <= push && full && !pop;
      break_q   <= brk_evt;
    end
  end

  assign head       = mem[rd_q];
  assign m_valid    = (count_q != '0);
  assign m_data     = m_valid ? head[PAYLOAD_BITS-1:0] : '0;
  assign m_status   = m_valid ? head[ENTRY_W-1:PAYLOAD_BITS] : 2'b00;
  assign fifo_count = count_q;
  assign overrun    = overrun_q;
  assign break_det  = break_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 and an 8E1 instance (depth 4) checked against
// a scoreboard of expected {status, data} entries.
module tb_uart_rx_fifo;
  localparam int BIT_CLKS = 160;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn, rxd_a, rxd_b, en_a, en_b, rdy_a, rdy_b;
  logic [7:0] data_a, data_b;
  logic [1:0] stat_a, stat_b;
  logic       valid_a, valid_b, ovr_a, ovr_b, brk_a, brk_b;
  logic [2:0] cnt_a, cnt_b;

  uart_rx_fifo #(.CLK_HZ(100_000_000), .BIT_RATE(625_000), .OVERSAMPLE(16), .PAYLOAD_BITS(8),
                 .STOP_BITS(1), .PARITY(0), .FIFO_DEPTH(4)) u_dut_n (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd_a), .uart_rx_en(en_a), .m_data(data_a),
    .m_status(stat_a), .m_valid(valid_a), .m_ready(rdy_a), .fifo_count(cnt_a),
    .overrun(ovr_a), .break_det(brk_a));

  uart_rx_fifo #(.CLK_HZ(100_000_000), .BIT_RATE(625_000), .OVERSAMPLE(16), .PAYLOAD_BITS(8),
                 .STOP_BITS(1), .PARITY(2), .FIFO_DEPTH(4)) u_dut_e (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd_b), .uart_rx_en(en_b), .m_data(data_b),
    .m_status(stat_b), .m_valid(valid_b), .m_ready(rdy_b), .fifo_count(cnt_b),
    .overrun(ovr_b), .break_det(brk_b));

  int n_vec = 0;
  int n_err = 0;
  int ovr_cnt_a = 0;
  int brk_cnt_a = 0;
  logic [9:0] exp_a[$];
  logic [9:0] exp_b[$];

  // Counting high cycles makes a stretched pulse show up as an extra count.
  always @(negedge clk) begin
    if (ovr_a === 1'b1) ovr_cnt_a <= ovr_cnt_a + 1;
    if (brk_a === 1'b1) brk_cnt_a <= brk_cnt_a + 1;
  end

  task automatic drive_line(input bit sel, input logic v);
    if (sel) rxd_b = v;
    else     rxd_a = v;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input bit sel, input logic [11:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      drive_line(sel, bits[i]);
      wait_clks(BIT_CLKS);
    end
    drive_line(sel, 1'b1);
  endtask

  task automatic send_n(input logic [7:0] d, input logic stop_v);
    send_bits(1'b0, {2'b11, stop_v, d, 1'b0}, 10);
  endtask

  task automatic send_e(input logic [7:0] d, input logic p);
    send_bits(1'b1, {1'b1, 1'b1, p, d, 1'b0}, 11);
  endtask

  task automatic wait_valid_a(input int budget);
    for (int i = 0; i < budget && valid_a !== 1'b1; i++) @(negedge clk);
  endtask

  task automatic pop_a();
    rdy_a = 1'b1;
    wait_clks(1);
    rdy_a = 1'b0;
  endtask

  task automatic pop_b();
    rdy_b = 1'b1;
    wait_clks(1);
    rdy_b = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    wait_clks(3);
    @(negedge clk);
    n_vec += 8;
    if (valid_a !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", valid_a); end
    if (data_a !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h want 00", data_a); end
    if (stat_a !== 2'b00) begin n_err++; $display("FAIL rst_status: got %b want 00", stat_a); end
    if (cnt_a !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", cnt_a); end
    if (ovr_a !== 1'b0) begin n_err++; $display("FAIL rst_overrun: got %b want 0", ovr_a); end
    if (brk_a !== 1'b0) begin n_err++; $display("FAIL rst_break: got %b want 0", brk_a); end
    if (valid_b !== 1'b0) begin n_err++; $display("FAIL rst_valid_e: got %b want 0", valid_b); end
    if (cnt_b !== 3'd0) begin n_err++; $display("FAIL rst_count_e: got %0d want 0", cnt_b); end
    resetn = 1'b1;
    wait_clks(5);
  endtask

  task automatic test_8n1();
    logic [9:0] e;
    exp_a.push_back({2'b00, 8'hA5});
    send_bits(1'b0, {2'b11, 1'b1, 8'hA5, 1'b0}, 9);
    wait_clks(50);
    @(negedge clk);
    n_vec++;
    if (valid_a !== 1'b0) begin n_err++; $display("FAIL 8n1_early: got %b want 0", valid_a); end
    wait_clks(110);
    wait_valid_a(400);
    e = exp_a.pop_front();
    n_vec += 3;
    if (valid_a !== 1'b1) begin n_err++; $display("FAIL 8n1_valid: got %b want 1", valid_a); end
    if (cnt_a !== 3'd1) begin n_err++; $display("FAIL 8n1_count: got %0d want 1", cnt_a); end
    if ({stat_a, data_a} !== e) begin
      n_err++; $display("FAIL 8n1_head: got %h want %h", {stat_a, data_a}, e);
    end
    pop_a();
    @(negedge clk);
    n_vec++;
    if (valid_a !== 1'b0 || cnt_a !== 3'd0) begin
      n_err++; $display("FAIL 8n1_pop: got valid %b count %0d want 0/0", valid_a, cnt_a);
    end
  endtask

  task automatic test_parity();
    logic [9:0] e;
    logic [7:0] d = 8'h07;
    for (int p = 0; p < 2; p++) begin
      exp_b.push_back({1'b0, ^d ^ 1'(p), d});
      send_e(d, 1'(p));
    end
    wait_clks(BIT_CLKS);
    @(negedge clk);
    n_vec++;
    if (cnt_b !== 3'd2) begin n_err++; $display("FAIL par_count: got %0d want 2", cnt_b); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      e = exp_b.pop_front();
      n_vec++;
      if (valid_b !== 1'b1 || {stat_b, data_b} !== e) begin
        n_err++; $display("FAIL par_head%0d: got %b/%h want 1/%h", k, valid_b, {stat_b, data_b}, e);
      end
      pop_b();
    end
  endtask

  task automatic test_frame_break();
    logic [9:0] e;
    int b0;
    exp_a.push_back({2'b10, 8'h3C});
    send_n(8'h3C, 1'b0);
    wait_clks(2 * BIT_CLKS);
    wait_valid_a(400);
    e = exp_a.pop_front();
    n_vec++;
    if (valid_a !== 1'b1 || {stat_a, data_a} !== e) begin
      n_err++; $display("FAIL ferr_head: got %b/%h want 1/%h", valid_a, {stat_a, data_a}, e);
    end
    pop_a();
    b0 = brk_cnt_a;
    rxd_a = 1'b0;
    wait_clks(12 * BIT_CLKS);
    @(negedge clk);
    n_vec += 2;
    if (brk_cnt_a - b0 !== 1) begin
      n_err++; $display("FAIL brk_pulse: got %0d cycles want 1", brk_cnt_a - b0);
    end
    if (cnt_a !== 3'd0) begin n_err++; $display("FAIL brk_nopush: got %0d want 0", cnt_a); end
    rxd_a = 1'b1;
    wait_clks(BIT_CLKS);
    exp_a.push_back({2'b00, 8'h11});
    send_n(8'h11, 1'b1);
    wait_valid_a(400);
    e = exp_a.pop_front();
    n_vec++;
    if (valid_a !== 1'b1 || {stat_a, data_a} !== e) begin
      n_err++; $display("FAIL brk_resume: got %b/%h want 1/%h", valid_a, {stat_a, data_a}, e);
    end
    pop_a();
  endtask

  task automatic test_glitch();
    logic [9:0] e;
    rxd_a = 1'b0;
    wait_clks(70);
    rxd_a = 1'b1;
    wait_clks(3 * BIT_CLKS);
    @(negedge clk);
    n_vec++;
    if (cnt_a !== 3'd0 || valid_a !== 1'b0) begin
      n_err++; $display("FAIL glitch_nopush: got count %0d valid %b want 0/0", cnt_a, valid_a);
    end
    exp_a.push_back({2'b00, 8'h42});
    send_n(8'h42, 1'b1);
    wait_valid_a(400);
    e = exp_a.pop_front();
    n_vec++;
    if (valid_a !== 1'b1 || {stat_a, data_a} !== e) begin
      n_err++; $display("FAIL glitch_after: got %b/%h want 1/%h", valid_a, {stat_a, data_a}, e);
    end
    pop_a();
  endtask

  task automatic test_overrun();
    logic [9:0] e;
    int o0 = ovr_cnt_a;
    for (int i = 1; i <= 4; i++) begin
      exp_a.push_back({2'b00, 8'(i)});
      send_n(8'(i), 1'b1);
    end
    @(negedge clk);
    n_vec++;
    if (ovr_cnt_a - o0 !== 0) begin
      n_err++; $display("FAIL ovr_early: got %0d pulses want 0", ovr_cnt_a - o0);
    end
    send_n(8'h05, 1'b1);
    @(negedge clk);
    n_vec += 2;
    if (ovr_cnt_a - o0 !== 1) begin
      n_err++; $display("FAIL ovr_pulse: got %0d cycles want 1", ovr_cnt_a - o0);
    end
    if (cnt_a !== 3'd4) begin n_err++; $display("FAIL ovr_count: got %0d want 4", cnt_a); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      e = exp_a.pop_front();
      n_vec++;
      if (valid_a !== 1'b1 || {stat_a, data_a} !== e) begin
        n_err++; $display("FAIL ovr_head%0d: got %b/%h want 1/%h", k, valid_a, {stat_a, data_a}, e);
      end
      pop_a();
    end
    @(negedge clk);
    n_vec++;
    if (valid_a !== 1'b0) begin n_err++; $display("FAIL ovr_drained: got %b want 0", valid_a); end
  endtask

  task automatic test_rx_en();
    logic [9:0] e;
    send_bits(1'b0, {2'b11, 1'b1, 8'h55, 1'b0}, 5);
    wait_clks(40);
    en_a = 1'b0;
    wait_clks(5);
    en_a = 1'b1;
    wait_clks(10 * BIT_CLKS);
    @(negedge clk);
    n_vec++;
    if (cnt_a !== 3'd0) begin n_err++; $display("FAIL en_discard: got %0d want 0", cnt_a); end
    exp_a.push_back({2'b00, 8'h99});
    send_n(8'h99, 1'b1);
    wait_valid_a(400);
    e = exp_a.pop_front();
    n_vec++;
    if (valid_a !== 1'b1 || {stat_a, data_a} !== e) begin
      n_err++; $display("FAIL en_after: got %b/%h want 1/%h", valid_a, {stat_a, data_a}, e);
    end
    pop_a();
  endtask

  task automatic test_reset_mid();
    logic [9:0] e;
    send_n(8'h77, 1'b1);
    send_bits(1'b0, {2'b11, 1'b1, 8'h33, 1'b0}, 4);
    rxd_a = 1'b0;
    wait_clks(80);
    resetn = 1'b0;
    rxd_a = 1'b1;
    wait_clks(2);
    resetn = 1'b1;
    @(negedge clk);
    n_vec += 4;
    if (valid_a !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", valid_a); end
    if (cnt_a !== 3'd0) begin n_err++; $display("FAIL mid_count: got %0d want 0", cnt_a); end
    if ({stat_a, data_a} !== 10'h000) begin
      n_err++; $display("FAIL mid_head: got %h want 000", {stat_a, data_a});
    end
    if (ovr_a !== 1'b0 || brk_a !== 1'b0) begin
      n_err++; $display("FAIL mid_pulses: got %b%b want 00", ovr_a, brk_a);
    end
    wait_clks(12 * BIT_CLKS);
    @(negedge clk);
    n_vec++;
    if (cnt_a !== 3'd0) begin n_err++; $display("FAIL mid_nopush: got %0d want 0", cnt_a); end
    exp_a.push_back({2'b00, 8'h5A});
    send_n(8'h5A, 1'b1);
    wait_valid_a(400);
    e = exp_a.pop_front();
    n_vec++;
    if (valid_a !== 1'b1 || {stat_a, data_a} !== e) begin
      n_err++; $display("FAIL mid_clean: got %b/%h want 1/%h", valid_a, {stat_a, data_a}, e);
    end
    pop_a();
  endtask

  initial begin
    resetn = 1'b0;
    rxd_a = 1'b1;
    rxd_b = 1'b1;
    en_a = 1'b1;
    en_b = 1'b1;
    rdy_a = 1'b0;
    rdy_b = 1'b0;
    test_reset();
    test_8n1();
    test_parity();
    test_frame_break();
    test_glitch();
    test_overrun();
    test_rx_en();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
